// File: rtl/irq_arbiter_4.sv
// rtl/irq_arbiter_4.sv - four-source interrupt arbiter/sequencer; optional IRQ_ROUND_ROBIN_EN selects rotating priority
module irq_arbiter_4 #(
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter logic [31:0] VECTOR_STRIDE = 32'd4,
    parameter logic [3:0]  EDGE_MASK     = 4'b0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_irq_src,
    input  logic [3:0]  i_irq_en,
    input  logic        i_global_en,
    input  logic        i_irq_ack,
    input  logic        i_irq_eoi,
    output logic        o_irq_req,
    output logic [1:0]  o_irq_id,
    output logic [31:0] o_irq_vector,
    output logic [3:0]  o_pending,
    output logic        o_in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  pending;
    logic [3:0]  pending_next;
    logic [3:0]  history;
    logic [3:0]  eligible;
    logic [3:0]  ack_clear;
    logic [1:0]  irq_id;
    logic [1:0]  id_next;
    logic [1:0]  sel_id;
    logic        sel_valid;
    logic [31:0] sel_vector;
    logic [31:0] irq_vector;
    logic [31:0] vector_next;

    assign eligible = pending & i_irq_en;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_cand;

    // Rotating search: start just after the last granted source, wrapping 3->0.
    // Iterating from the farthest candidate down lets the nearest one win.
    always_comb begin
        sel_id    = 2'd0;
        sel_valid = 1'b0;
        rr_cand   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            rr_cand = rr_ptr + 2'(k);
            if (eligible[rr_cand]) begin
                sel_id    = rr_cand;
                sel_valid = 1'b1;
            end
        end
    end

    // Last-granted pointer advances on each accepted trap; 3 at reset so source 0 is searched first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= 2'd3;
        end else if (state == REQ && i_irq_ack) begin
            rr_ptr <= irq_id;
        end
    end
`else
    // Fixed priority: source 3 highest, source 0 lowest.
    always_comb begin
        sel_valid = |eligible;
        if (eligible[3]) begin
            sel_id = 2'd3;
        end else if (eligible[2]) begin
            sel_id = 2'd2;
        end else if (eligible[1]) begin
            sel_id = 2'd1;
        end else begin
            sel_id = 2'd0;
        end
    end
`endif

    assign sel_vector = VECTOR_BASE + 32'(sel_id) * VECTOR_STRIDE;

    // Next-state logic: arbitrate in IDLE, hold the presented id in REQ, wait for eoi in SERVICE.
    always_comb begin
        state_next  = state;
        id_next     = irq_id;
        vector_next = irq_vector;
        ack_clear   = 4'b0000;
        case (state)
            IDLE: begin
                if (i_global_en && sel_valid) begin
                    state_next  = REQ;
                    id_next     = sel_id;
                    vector_next = sel_vector;
                end
            end
            REQ: begin
                if (i_irq_ack) begin
                    state_next = SERVICE;
                    ack_clear  = 4'b0001 << irq_id;
                end else if (!eligible[irq_id] || !i_global_en) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (i_irq_eoi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Edge sources latch a rising edge until acked (a new edge beats a same-cycle clear);
    // level sources simply follow the registered line.
    assign pending_next = (EDGE_MASK & ((i_irq_src & ~history) | (pending & ~ack_clear)))
                        | (~EDGE_MASK & i_irq_src);

    // State, pending, edge history and presented id/vector registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            pending    <= 4'b0000;
            history    <= 4'b0000;
            irq_id     <= 2'd0;
            irq_vector <= VECTOR_BASE;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            history    <= i_irq_src;
            irq_id     <= id_next;
            irq_vector <= vector_next;
        end
    end

    assign o_irq_req    = (state == REQ);
    assign o_in_service = (state == SERVICE);
    assign o_irq_id     = irq_id;
    assign o_irq_vector = irq_vector;
    assign o_pending    = pending;

endmodule

// File: tb/tb_irq_arbiter_4.sv
// tb/tb_irq_arbiter_4.sv - self-checking bench for irq_arbiter_4 (default fixed-priority build)
module tb_irq_arbiter_4;

    localparam logic [31:0] VB_A   = 32'h0000_0100;
    localparam logic [31:0] VB_B   = 32'hFFFF_FFFC;
    localparam logic [31:0] STRIDE = 32'd4;
    localparam logic [3:0]  EMASK  = 4'b0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic [3:0]  en;
    logic        gen;
    logic        ack;
    logic        eoi;

    logic        req_a, svc_a, req_b, svc_b;
    logic [1:0]  id_a, id_b;
    logic [31:0] vec_a, vec_b;
    logic [3:0]  pend_a, pend_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    irq_arbiter_4 #(.VECTOR_BASE(VB_A), .VECTOR_STRIDE(STRIDE), .EDGE_MASK(EMASK)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_irq_src(src), .i_irq_en(en), .i_global_en(gen),
        .i_irq_ack(ack), .i_irq_eoi(eoi), .o_irq_req(req_a), .o_irq_id(id_a),
        .o_irq_vector(vec_a), .o_pending(pend_a), .o_in_service(svc_a)
    );

    irq_arbiter_4 #(.VECTOR_BASE(VB_B), .VECTOR_STRIDE(STRIDE), .EDGE_MASK(EMASK)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_irq_src(src), .i_irq_en(en), .i_global_en(gen),
        .i_irq_ack(ack), .i_irq_eoi(eoi), .o_irq_req(req_b), .o_irq_id(id_b),
        .o_irq_vector(vec_b), .o_pending(pend_b), .o_in_service(svc_b)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting, 1 = presenting, 2 = handler running.
    int         m_phase;
    logic [3:0] m_pend;
    logic [3:0] m_prev_src;
    logic [1:0] m_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        logic [3:0] elig;
        int         nphase;
        int         acked;
        logic [1:0] nid;
        if (rst) begin
            m_phase    = 0;
            m_pend     = 4'b0000;
            m_prev_src = 4'b0000;
            m_id       = 2'd0;
            return;
        end
        elig   = m_pend & en;
        nphase = m_phase;
        nid    = m_id;
        acked  = -1;
        if (m_phase == 0) begin
            if (gen && elig != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (elig[i]) nid = 2'(i);
                end
                nphase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                nphase = 2;
                acked  = int'(m_id);
            end else if (!elig[m_id] || !gen) begin
                nphase = 0;
            end
        end else begin
            if (eoi) nphase = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (EMASK[i]) begin
                if (src[i] && !m_prev_src[i]) m_pend[i] = 1'b1;
                else if (acked == i)         m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = src[i];
            end
        end
        m_prev_src = src;
        m_phase    = nphase;
        m_id       = nid;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare both DUTs 1 time unit later.
    task automatic step(input logic r, input logic [3:0] s, input logic [3:0] e,
                        input logic g, input logic a, input logic o);
        rst = r; src = s; en = e; gen = g; ack = a; eoi = o;
        @(posedge clk);
        model_update();
        #1;
        chk("req",     32'(req_a),  32'(m_phase == 1));
        chk("svc",     32'(svc_a),  32'(m_phase == 2));
        chk("id",      32'(id_a),   32'(m_id));
        chk("pending", 32'(pend_a), 32'(m_pend));
        chk("vec_a",   vec_a,       VB_A + 32'(m_id) * STRIDE);
        chk("vec_b",   vec_b,       VB_B + 32'(m_id) * STRIDE);
        chk("req_b",   32'(req_b),  32'(req_a));
        chk("pend_b",  32'(pend_b), 32'(m_pend));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] src;
        logic       gen;
        logic       ack;
        logic       eoi;
        logic       req;
        logic [1:0] id;
        logic [3:0] pend;
        logic       svc;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // rst src gen ack eoi | req id pend svc
        tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1111, 1'b1};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0100, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[14] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b0};
        tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
        tbl[17] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        tbl[18] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};

        rst = 1'b1; src = 4'b0000; en = 4'b1111; gen = 1'b0; ack = 1'b0; eoi = 1'b0;
        @(negedge clk);

        // Edge pulse on source 2, global-enable gating, re-pulse during ack.
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].src, 4'b1111, tbl[i].gen, tbl[i].ack, tbl[i].eoi);
            chk($sformatf("tbl%0d_req", i),  32'(req_a),  32'(tbl[i].req));
            chk($sformatf("tbl%0d_id", i),   32'(id_a),   32'(tbl[i].id));
            chk($sformatf("tbl%0d_pend", i), 32'(pend_a), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_svc", i),  32'(svc_a),  32'(tbl[i].svc));
            chk($sformatf("tbl%0d_vec", i),  vec_a,       VB_A + 32'(tbl[i].id) * 32'd4);
        end

        // Level sources 1 and 3 together: 3 wins, re-presented while high, then 1.
        step(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("lvl_first_id3", 32'(id_a), 32'd3);
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("lvl_again_req", 32'(req_a), 32'd1);
        chk("lvl_again_id3", 32'(id_a), 32'd3);
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("lvl_then_id1", 32'(id_a), 32'd1);
        chk("vec_wrap", vec_b, 32'h0000_0000);

        // Withdraw on level source 0, then ack coinciding with the drop.
        step(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("wd_req_up", 32'(req_a), 32'd1);
        step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("wd_req_down", 32'(req_a), 32'd0);
        chk("wd_no_svc", 32'(svc_a), 32'd0);
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("wd_ack_wins", 32'(svc_a), 32'd1);

        // Reset in the middle of SERVICE.
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_pend", 32'(pend_a), 32'd1);
        step(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("rst_svc", 32'(svc_a), 32'd0);
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_pend", 32'(pend_a), 32'd0);
        chk("rst_vec_b", vec_b, 32'hFFFF_FFFC);
        chk("rst_vec_a", vec_a, 32'h0000_0100);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
